// File: rtl/cj.sv
// Co-simulation host-interface checker: tracks the tohost completion word,
// a commit watchdog, the retired-instruction count and phase-marker decode.
module cj #(
  parameter logic [63:0] TOHOST_ADDR  = 64'h0000_0000_8000_1000,
  parameter int unsigned WATCHDOG     = 50000,
  parameter logic [63:0] TIMEOUT_CODE = 64'd5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        commit_valid,
  input  logic [31:0] commit_inst,
  input  logic        mem_wr_valid,
  input  logic [63:0] mem_wr_addr,
  input  logic [63:0] mem_wr_data,
  input  logic        host_set_valid,
  input  logic [63:0] host_set_value,
  output logic [63:0] tohost,
  output logic        marker_valid,
  output logic [2:0]  marker_id,
  output logic [63:0] commit_count
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned WD_W   = 32;
  localparam int unsigned ID_W   = 3;

  localparam logic [WD_W-1:0]   WD_LIMIT   = WD_W'(WATCHDOG);
  localparam logic              WD_ENABLED = (WATCHDOG != 0);
  localparam logic [19:0]       MARKER_LO  = 20'h02013;

  logic [DATA_W-1:0] tohost_q, tohost_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              marker_valid_q, marker_valid_d;
  logic [ID_W-1:0]   marker_id_q, marker_id_d;

  logic done;
  logic expire;
  logic store_hit;
  logic marker_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tohost_q       <= '0;
      count_q        <= '0;
      wdog_q         <= '0;
      marker_valid_q <= 1'b0;
      marker_id_q    <= '0;
    end else begin
      tohost_q       <= tohost_d;
      count_q        <= count_d;
      wdog_q         <= wdog_d;
      marker_valid_q <= marker_valid_d;
      marker_id_q    <= marker_id_d;
    end
  end

  // The done latch is the finished bit of tohost itself.
  always_comb begin
    done       = tohost_q[0];
    expire     = WD_ENABLED && (wdog_q == WD_LIMIT) && !done;
    store_hit  = mem_wr_valid && (mem_wr_addr == TOHOST_ADDR) && (mem_wr_data != '0);
    marker_hit = commit_valid && (commit_inst[19:0] == MARKER_LO) && (commit_inst[31:23] == 9'd0);
  end

  // tohost priority: side-band write, then watchdog, then store (blocked once done).
  always_comb begin
    tohost_d = tohost_q;
    if (host_set_valid) begin
      tohost_d = host_set_value;
    end else if (expire) begin
      tohost_d = TIMEOUT_CODE;
    end else if (store_hit && !done) begin
      tohost_d = mem_wr_data;
    end
  end

  // Idle-cycle counter parks at the limit once reached.
  always_comb begin
    wdog_d = wdog_q;
    if (commit_valid || !WD_ENABLED) begin
      wdog_d = '0;
    end else if (wdog_q != WD_LIMIT) begin
      wdog_d = wdog_q + WD_W'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    if (commit_valid && (count_q != {DATA_W{1'b1}})) begin
      count_d = count_q + DATA_W'(1);
    end
  end

  always_comb begin
    marker_valid_d = marker_hit;
    marker_id_d    = marker_id_q;
    if (marker_hit) begin
      marker_id_d = commit_inst[22:20];
    end
  end

  assign tohost       = tohost_q;
  assign commit_count = count_q;
  assign marker_valid = marker_valid_q;
  assign marker_id    = marker_id_q;

endmodule

// File: tb/tb_cj.sv
// Self-checking bench for cj: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural model.
module tb_cj;

  localparam logic [63:0] TA  = 64'h0000_0000_8000_1000;
  localparam int unsigned WD  = 10;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        commit_valid;
  logic [31:0] commit_inst;
  logic        mem_wr_valid;
  logic [63:0] mem_wr_addr;
  logic [63:0] mem_wr_data;
  logic        host_set_valid;
  logic [63:0] host_set_value;
  logic [63:0] tohost;
  logic        marker_valid;
  logic [2:0]  marker_id;
  logic [63:0] commit_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [63:0] m_tohost;
  logic [63:0] m_cnt;
  int          m_idle;
  logic        m_mv;
  logic [2:0]  m_mid;

  cj #(.TOHOST_ADDR(TA), .WATCHDOG(WD), .TIMEOUT_CODE(64'd5)) dut (
    .clock          (clock),
    .reset          (reset),
    .commit_valid   (commit_valid),
    .commit_inst    (commit_inst),
    .mem_wr_valid   (mem_wr_valid),
    .mem_wr_addr    (mem_wr_addr),
    .mem_wr_data    (mem_wr_data),
    .host_set_valid (host_set_valid),
    .host_set_value (host_set_value),
    .tohost         (tohost),
    .marker_valid   (marker_valid),
    .marker_id      (marker_id),
    .commit_count   (commit_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        cv;
    logic [31:0] inst;
    logic        wv;
    logic [63:0] addr;
    logic [63:0] data;
    logic        hs;
    logic [63:0] hv;
    logic [63:0] exp_tohost;
    logic        exp_mv;
    logic [2:0]  exp_mid;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic rst, logic cv, logic [31:0] inst, logic wv,
                              logic [63:0] addr, logic [63:0] data, logic hs,
                              logic [63:0] hv, logic [63:0] et, logic emv, logic [2:0] emid);
    vec_t v;
    v.rst = rst; v.cv = cv; v.inst = inst; v.wv = wv; v.addr = addr; v.data = data;
    v.hs = hs; v.hv = hv; v.exp_tohost = et; v.exp_mv = emv; v.exp_mid = emid;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_tohost = '0; m_cnt = '0; m_idle = 0; m_mv = 1'b0; m_mid = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic m_clock();
    logic hit, exp;
    hit = mem_wr_valid && (mem_wr_addr == TA) && (mem_wr_data != 64'd0);
    exp = (m_idle >= int'(WD)) && !m_tohost[0];
    if (host_set_valid)            m_tohost = host_set_value;
    else if (exp)                  m_tohost = 64'd5;
    else if (hit && !m_tohost[0])  m_tohost = mem_wr_data;
    m_idle = commit_valid ? 0 : m_idle + 1;
    if (commit_valid && m_cnt != {64{1'b1}}) m_cnt = m_cnt + 64'd1;
    m_mv = commit_valid && (commit_inst[19:0] == 20'h02013) && (commit_inst[31:23] == 9'd0);
    if (m_mv) m_mid = commit_inst[22:20];
  endtask

  task automatic clr_in();
    commit_valid = 1'b0; commit_inst = '0; mem_wr_valid = 1'b0; mem_wr_addr = '0;
    mem_wr_data = '0; host_set_valid = 1'b0; host_set_value = '0;
  endtask

  task automatic step();
    m_clock();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_model(input string name);
    chk({name, ".tohost"}, tohost, m_tohost);
    chk({name, ".count"}, commit_count, m_cnt);
    chk({name, ".mvalid"}, 64'(marker_valid), 64'(m_mv));
    if (m_mv) chk({name, ".mid"}, 64'(marker_id), 64'(m_mid));
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear before any edge.
  task automatic hw_reset();
    reset = 1'b1;
    m_reset();
    #1;
    chk("rst.tohost", tohost, 64'd0);
    chk("rst.count", commit_count, 64'd0);
    chk("rst.mvalid", 64'(marker_valid), 64'd0);
    chk("rst.mid", 64'(marker_id), 64'd0);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    clr_in();
    m_reset();

    vecs[0]  = mk(1, 1, NOP,          1, TA,      64'h1, 0, 0,     64'h1, 0, 0);
    vecs[1]  = mk(0, 1, NOP,          1, TA,      64'h3, 0, 0,     64'h1, 0, 0);
    vecs[2]  = mk(1, 1, NOP,          1, TA,      64'h0, 0, 0,     64'h0, 0, 0);
    vecs[3]  = mk(0, 1, NOP,          1, TA + 8,  64'h2, 0, 0,     64'h0, 0, 0);
    vecs[4]  = mk(0, 1, NOP,          1, TA,      64'h2, 0, 0,     64'h2, 0, 0);
    vecs[5]  = mk(0, 1, NOP,          1, TA,      64'h3, 0, 0,     64'h3, 0, 0);
    vecs[6]  = mk(1, 1, 32'h00402013, 0, 0,       0,     0, 0,     64'h0, 1, 4);
    vecs[7]  = mk(0, 1, 32'h00802013, 0, 0,       0,     0, 0,     64'h0, 0, 0);
    vecs[8]  = mk(0, 1, 32'h00002033, 0, 0,       0,     0, 0,     64'h0, 0, 0);
    vecs[9]  = mk(0, 0, 32'h00302013, 0, 0,       0,     0, 0,     64'h0, 0, 0);
    vecs[10] = mk(0, 1, 32'h00702013, 0, 0,       0,     0, 0,     64'h0, 1, 7);
    vecs[11] = mk(1, 1, NOP,          1, TA,      64'h1, 1, 64'h5, 64'h5, 0, 0);
    vecs[12] = mk(0, 1, NOP,          1, TA,      64'h1, 0, 0,     64'h5, 0, 0);
    vecs[13] = mk(0, 1, NOP,          0, 0,       0,     1, 64'h8, 64'h8, 0, 0);
    vecs[14] = mk(0, 1, 32'h00002013, 1, TA,      64'h1, 0, 0,     64'h1, 1, 0);

    reset = 1'b1;
    #3;
    reset = 1'b0;

    // Directed vector table
    foreach (vecs[i]) begin
      if (vecs[i].rst) hw_reset();
      commit_valid = vecs[i].cv; commit_inst = vecs[i].inst;
      mem_wr_valid = vecs[i].wv; mem_wr_addr = vecs[i].addr; mem_wr_data = vecs[i].data;
      host_set_valid = vecs[i].hs; host_set_value = vecs[i].hv;
      step();
      clr_in();
      chk($sformatf("vec%0d.tohost", i), tohost, vecs[i].exp_tohost);
      chk($sformatf("vec%0d.mvalid", i), 64'(marker_valid), 64'(vecs[i].exp_mv));
      if (vecs[i].exp_mv) chk($sformatf("vec%0d.mid", i), 64'(marker_id), 64'(vecs[i].exp_mid));
    end

    // Watchdog: ten idle cycles reach the limit, timeout lands one cycle later
    hw_reset();
    clr_in();
    for (int k = 1; k <= 11; k++) begin
      step();
      chk($sformatf("wdog.c%0d", k), tohost, (k < 11) ? 64'd0 : 64'd5);
    end
    commit_valid = 1'b1; commit_inst = NOP;
    step();
    clr_in();
    chk("wdog.after_commit", tohost, 64'd5);
    mem_wr_valid = 1'b1; mem_wr_addr = TA; mem_wr_data = 64'h7;
    step();
    clr_in();
    chk("wdog.frozen_store", tohost, 64'd5);

    // Mid-round asynchronous reset with tohost=1 and 37 commits
    hw_reset();
    for (int k = 0; k < 37; k++) begin
      commit_valid = 1'b1; commit_inst = NOP;
      mem_wr_valid = (k == 5); mem_wr_addr = TA; mem_wr_data = 64'h1;
      step();
    end
    clr_in();
    chk("mid.count", commit_count, 64'd37);
    chk("mid.tohost", tohost, 64'd1);
    hw_reset();
    mem_wr_valid = 1'b1; mem_wr_addr = TA; mem_wr_data = 64'h1;
    step();
    clr_in();
    chk("mid.rearm", tohost, 64'd1);

    // Randomized traffic against the model
    hw_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 149) == 0) hw_reset();
      commit_valid = ($urandom_range(0, 99) < 75);
      case ($urandom_range(0, 3))
        0: commit_inst = {9'd0, 3'($urandom_range(0, 7)), 20'h02013};
        1: commit_inst = {9'($urandom_range(1, 511)), 3'($urandom_range(0, 7)), 20'h02013};
        2: commit_inst = {12'd0, 20'($urandom)};
        default: commit_inst = 32'($urandom);
      endcase
      mem_wr_valid = ($urandom_range(0, 99) < 30);
      mem_wr_addr  = ($urandom_range(0, 1) == 0) ? TA : TA + 64'(8 * $urandom_range(1, 4));
      case ($urandom_range(0, 3))
        0: mem_wr_data = 64'd0;
        1: mem_wr_data = {32'($urandom), 31'($urandom), 1'b0};
        default: mem_wr_data = {32'($urandom), 32'($urandom)};
      endcase
      host_set_valid = ($urandom_range(0, 99) < 3);
      host_set_value = {32'($urandom), 32'($urandom)};
      step();
      chk_model($sformatf("rnd%0d", n));
    end
    clr_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
